// File: rtl/onewire_slave.sv
// rtl/onewire_slave.sv - 1-Wire responder: reset/presence, RX write slots, TX read slots
module onewire_slave #(
  parameter int CLK_MHZ    = 50,
  parameter int SAMPLE_US  = 30,
  parameter int TXHOLD_US  = 30,
  parameter int SLOTMAX_US = 120,
  parameter int RSTMIN_US  = 400,
  parameter int PDWAIT_US  = 30,
  parameter int PDLEN_US   = 120
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_dq,
  output logic       o_dq,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_load,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_bus_reset,
  output logic       o_err
);

  localparam logic [15:0] SAMPLE_C   = 16'(SAMPLE_US * CLK_MHZ);
  localparam logic [15:0] TXHOLD_C   = 16'(TXHOLD_US * CLK_MHZ);
  localparam logic [15:0] SLOTMAX_C  = 16'(SLOTMAX_US * CLK_MHZ);
  localparam logic [15:0] RSTMIN_C   = 16'(RSTMIN_US * CLK_MHZ);
  localparam logic [15:0] PDWAIT_END = 16'(PDWAIT_US * CLK_MHZ - 1);
  localparam logic [15:0] PDLEN_END  = 16'(PDLEN_US * CLK_MHZ - 1);

  typedef enum logic [2:0] {S_IDLE, S_SLOT, S_PD_WAIT, S_PD_DRIVE, S_PD_REL} state_t;

  state_t      r_state;
  logic        r_dq_m, r_dq_s, r_dq_p;
  logic [15:0] r_cnt;
  logic [2:0]  r_bitn;
  logic [7:0]  r_tx_byte;
  logic [7:0]  r_rx_sr;
  logic        r_bit;

  logic        w_fall, w_rise, w_tx_bit;
  logic [15:0] w_cnt_inc;
  logic [7:0]  w_rx_next;

  assign w_fall    = r_dq_p & ~r_dq_s;
  assign w_rise    = ~r_dq_p & r_dq_s;
  assign w_tx_bit  = r_tx_byte[r_bitn];
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_rx_next = {r_bit, r_rx_sr[7:1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_dq_m      <= 1'b1;
      r_dq_s      <= 1'b1;
      r_dq_p      <= 1'b1;
      r_cnt       <= 16'd0;
      r_bitn      <= 3'd0;
      r_tx_byte   <= 8'd0;
      r_rx_sr     <= 8'd0;
      r_bit       <= 1'b1;
      o_dq        <= 1'b1;
      o_tx_busy   <= 1'b0;
      o_tx_done   <= 1'b0;
      o_rx_byte   <= 8'd0;
      o_rx_valid  <= 1'b0;
      o_bus_reset <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      r_dq_m      <= i_dq;
      r_dq_s      <= r_dq_m;
      r_dq_p      <= r_dq_s;
      r_cnt       <= w_cnt_inc;
      o_tx_done   <= 1'b0;
      o_rx_valid  <= 1'b0;
      o_bus_reset <= 1'b0;
      o_err       <= 1'b0;
      if (i_tx_load && !o_tx_busy) begin
        r_tx_byte <= i_tx_byte;
        o_tx_busy <= 1'b1;
      end
      case (r_state)
        S_IDLE, S_PD_WAIT: begin
          o_dq <= 1'b1;
          // A fall takes priority over the presence-wait timeout.
          if (w_fall) begin
            r_state <= S_SLOT;
            r_cnt   <= 16'd0;
            r_bit   <= 1'b1;
            if (o_tx_busy && !w_tx_bit) o_dq <= 1'b0;
          end else if (r_state == S_PD_WAIT && r_cnt == PDWAIT_END) begin
            r_state <= S_PD_DRIVE;
            r_cnt   <= 16'd0;
            o_dq    <= 1'b0;
          end
        end
        S_SLOT: begin
          if (w_rise) begin
            o_dq    <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            if (r_cnt >= RSTMIN_C) begin
              o_bus_reset <= 1'b1;
              r_bitn      <= 3'd0;
              r_rx_sr     <= 8'd0;
              o_tx_busy   <= 1'b0;
              r_state     <= S_PD_WAIT;
            end else if (r_cnt > SLOTMAX_C) begin
              o_err   <= 1'b1;
              r_bitn  <= 3'd0;
              r_rx_sr <= 8'd0;
            end else begin
              r_bitn <= r_bitn + 3'd1;
              if (o_tx_busy) begin
                if (r_bitn == 3'd7) begin
                  o_tx_busy <= 1'b0;
                  o_tx_done <= 1'b1;
                end
              end else begin
                r_rx_sr <= w_rx_next;
                if (r_bitn == 3'd7) begin
                  o_rx_byte  <= w_rx_next;
                  o_rx_valid <= 1'b1;
                end
              end
            end
          end else begin
            if (r_cnt == TXHOLD_C) o_dq <= 1'b1;
            if (r_cnt == SAMPLE_C) r_bit <= r_dq_s;
          end
        end
        S_PD_DRIVE: begin
          if (r_cnt == PDLEN_END) begin
            o_dq    <= 1'b1;
            r_state <= S_PD_REL;
            r_cnt   <= 16'd0;
          end
        end
        S_PD_REL: begin
          if (r_dq_s) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 16'd0;
          o_dq    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_slave.sv
// tb/tb_onewire_slave.sv - randomized scoreboard bench for onewire_slave
`timescale 1ns/1ps
module tb_onewire_slave;
  localparam int MHZ        = 2;
  localparam int SAMPLE_US  = 30;
  localparam int TXHOLD_US  = 30;
  localparam int SLOTMAX_US = 120;
  localparam int RSTMIN_US  = 400;
  localparam int PDWAIT_US  = 30;
  localparam int PDLEN_US   = 120;

  typedef struct {int lo; int hi;} rng_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       r_mst = 1'b1;
  logic       tx_load = 1'b0;
  logic [7:0] tx_byte = 8'd0;
  logic       dq_in, dq_out, tx_busy, tx_done, rx_valid, bus_reset, err;
  logic [7:0] rx_byte;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_ev[$];
  rng_t exp_low[$];
  int run = 0;

  // Reference model state: armed flag, TX byte, shared bit index, RX accumulator.
  bit         m_busy = 0;
  logic [7:0] m_tx = 8'd0;
  int         m_n = 0;
  logic [7:0] m_acc = 8'd0;

  assign dq_in = r_mst & dq_out;
  always #5 clk = ~clk;

  onewire_slave #(
    .CLK_MHZ(MHZ), .SAMPLE_US(SAMPLE_US), .TXHOLD_US(TXHOLD_US), .SLOTMAX_US(SLOTMAX_US),
    .RSTMIN_US(RSTMIN_US), .PDWAIT_US(PDWAIT_US), .PDLEN_US(PDLEN_US)
  ) dut (
    .i_clk(clk), .i_rst_n(nrst), .i_dq(dq_in), .o_dq(dq_out),
    .i_tx_byte(tx_byte), .i_tx_load(tx_load), .o_tx_busy(tx_busy), .o_tx_done(tx_done),
    .o_rx_byte(rx_byte), .o_rx_valid(rx_valid), .o_bus_reset(bus_reset), .o_err(err)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic ev_check(input logic [9:0] got);
    logic [9:0] e;
    total++;
    if (exp_ev.size() == 0) begin
      bad++;
      $display("FAIL event_unexpected: got %h want none", got);
    end else begin
      e = exp_ev.pop_front();
      if (e !== got) begin
        bad++;
        $display("FAIL event: got %h want %h", got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid)  ev_check({2'd0, rx_byte});
    if (tx_done)   ev_check({2'd1, 8'd0});
    if (bus_reset) ev_check({2'd2, 8'd0});
    if (err)       ev_check({2'd3, 8'd0});
  end

  always @(negedge clk) begin
    rng_t r;
    if (!nrst) run = 0;
    else if (!dq_out) run++;
    else if (run > 0) begin
      total++;
      if (exp_low.size() == 0) begin
        bad++;
        $display("FAIL drive_low_unexpected: got %0d cycles want none", run);
      end else begin
        r = exp_low.pop_front();
        if (run < r.lo || run > r.hi) begin
          bad++;
          $display("FAIL drive_low_len: got %0d want %0d..%0d", run, r.lo, r.hi);
        end
      end
      run = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_busy = 0; m_n = 0; m_acc = 8'd0;
  endtask

  // Classify a master low pulse by its length in microseconds.
  task automatic m_pulse(input int us, input bit full_pd, output int rbit);
    rbit = -1;
    if (us >= RSTMIN_US) begin
      exp_ev.push_back({2'd2, 8'd0});
      m_busy = 0; m_n = 0; m_acc = 8'd0;
      if (full_pd) exp_low.push_back('{PDLEN_US * MHZ, PDLEN_US * MHZ});
    end else if (us > SLOTMAX_US) begin
      exp_ev.push_back({2'd3, 8'd0});
      m_n = 0; m_acc = 8'd0;
    end else if (m_busy) begin
      rbit = int'(m_tx[m_n]);
      if (rbit == 0) exp_low.push_back('{TXHOLD_US * MHZ, TXHOLD_US * MHZ + 2});
      m_n++;
      if (m_n == 8) begin
        m_busy = 0; m_n = 0;
        exp_ev.push_back({2'd1, 8'd0});
      end
    end else begin
      m_acc[m_n] = (us < SAMPLE_US);
      m_n++;
      if (m_n == 8) begin
        exp_ev.push_back({2'd0, m_acc});
        m_n = 0;
      end
    end
  endtask

  task automatic wait_high();
    int k = 0;
    while (!dq_in && k < 3000) begin tick(); k++; end
    if (!dq_in) chk("bus_release_timeout", 0, 1);
    repeat (10) tick();
  endtask

  task automatic slot(input int us);
    int rb;
    int ncyc = us * MHZ;
    m_pulse(us, 1'b1, rb);
    r_mst = 1'b0;
    for (int c = 0; c < ncyc || c <= 30; c++) begin
      if (c == ncyc) r_mst = 1'b1;
      tick();
      if (rb >= 0 && c == 29) chk("read_bit", int'(dq_in), rb);
    end
    r_mst = 1'b1;
    wait_high();
  endtask

  task automatic rst_pulse(input int us, input bit full_pd);
    int rb;
    int k;
    m_pulse(us, full_pd, rb);
    r_mst = 1'b0;
    repeat (us * MHZ) tick();
    r_mst = 1'b1;
    k = 0;
    while (!bus_reset && k < 20) begin tick(); k++; end
    chk("bus_reset_seen", int'(bus_reset), 1);
    k = 0;
    do begin tick(); k++; end while (dq_out && k < PDWAIT_US * MHZ + 20);
    chk("presence_start", k, PDWAIT_US * MHZ);
    if (full_pd) begin
      k = 0;
      while (!dq_out && k < PDLEN_US * MHZ + 20) begin tick(); k++; end
      wait_high();
    end
  endtask

  task automatic load(input logic [7:0] b);
    tx_byte = b;
    tx_load = 1'b1;
    tick();
    tx_load = 1'b0;
    if (!m_busy) begin m_busy = 1; m_tx = b; end
    chk("tx_busy_after_load", int'(tx_busy), int'(m_busy));
  endtask

  task automatic write_byte(input logic [7:0] b, input bit rnd);
    for (int i = 0; i < 8; i++) begin
      if (rnd) slot(b[i] ? int'($urandom_range(1, 7)) : int'($urandom_range(40, 100)));
      else     slot(b[i] ? 6 : 60);
    end
  endtask

  task automatic read_n(input int n, input bit rnd);
    for (int i = 0; i < n; i++) slot(rnd ? int'($urandom_range(2, 3)) : 2);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_dq_out"}, int'(dq_out), 1);
    chk({tag, "_tx_busy"}, int'(tx_busy), 0);
    chk({tag, "_rx_byte"}, int'(rx_byte), 0);
    chk({tag, "_pulses"}, int'({rx_valid, tx_done, bus_reset, err}), 0);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) tick();
    check_quiet("reset");
    nrst = 1'b1;
    repeat (5) tick();

    rst_pulse(480, 1'b1);
    write_byte(8'hA5, 1'b0);
    chk("rx_byte_a5", int'(rx_byte), 8'hA5);

    load(8'h3C);
    read_n(8, 1'b0);
    chk("tx_busy_after_8", int'(tx_busy), int'(m_busy));

    load(8'hFF);
    read_n(3, 1'b0);
    rst_pulse(500, 1'b1);
    chk("tx_busy_after_reset", int'(tx_busy), 0);
    write_byte(8'($urandom), 1'b1);

    slot(6);
    slot(60);
    slot(200);
    write_byte(8'h01, 1'b0);
    chk("rx_byte_01", int'(rx_byte), 8'h01);

    rst_pulse(480, 1'b0);
    repeat (100) tick();
    nrst = 1'b0;
    #1;
    check_quiet("nrst_mid_pd");
    m_reset();
    repeat (5) tick();
    nrst = 1'b1;
    tick();
    rst_pulse(480, 1'b1);

    for (int it = 0; it < 5; it++) begin
      write_byte(8'($urandom), 1'b1);
      b = 8'($urandom);
      load(b);
      load(~b);
      read_n(8, 1'b1);
      chk("tx_busy_rand", int'(tx_busy), int'(m_busy));
    end

    repeat (20) tick();
    chk("event_queue_empty", exp_ev.size(), 0);
    chk("drive_queue_empty", exp_low.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onewire_slave.md
# onewire_slave

1-Wire responder (slave device emulator) that answers the bus master. It detects a bus reset and replies with a presence pulse. It receives write slots LSB-first into bytes and drives read slots from a host-loaded byte. It connects to the same pulled-up DQ net as the master through a separate sense input and an open-drain-style drive output, and presents a byte-wide handshake to local logic, for example the SPI bridge.

## Interface
- CLK_MHZ, 50: CLK frequency in MHz; all µs thresholds are multiplied by it to get cycle counts.
- SAMPLE_US, 30: receive sample point after the slot's falling edge.
- TXHOLD_US, 30: how long a transmitted 0 is held low after the falling edge.
- SLOTMAX_US, 120: longest low pulse accepted as a bit slot.
- RSTMIN_US, 400: shortest low pulse accepted as a bus reset.
- PDWAIT_US, 30: delay from reset release to the start of the presence pulse.
- PDLEN_US, 120: presence pulse length.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous, active-low reset.
- DQ_IN  in  1  bus sense; asynchronous, passes through a 2-flop synchronizer.
- DQ_OUT  out  1  bus drive; 0 pulls DQ low, 1 releases it. Reset value 1.
- TX_BYTE  in  8  byte to return on the next 8 read slots.
- TX_LOAD  in  1  one-cycle strobe that captures TX_BYTE.
- TX_BUSY  out  1  a TX byte is armed or in progress. Reset value 0.
- TX_DONE  out  1  one-cycle pulse after the 8th TX bit. Reset value 0.
- RX_BYTE  out  8  last received byte, LSB = first bit on the bus. Reset value 0x00.
- RX_VALID  out  1  one-cycle pulse when RX_BYTE updates. Reset value 0.
- BUS_RESET  out  1  one-cycle pulse when a reset pulse is recognised. Reset value 0.
- ERR  out  1  one-cycle pulse on a malformed low pulse. Reset value 0.

## Operation
- The synchronized line is called dq_s. A falling edge (fall) is dq_s going 1→0; a rising edge (rise) is dq_s going 0→1.
- Counter cnt is 16 bits, saturates at 0xFFFF, and clears on entry to every state.
- Mode: TX mode while TX_BUSY=1, otherwise RX mode. Both modes share bit counter bitn (0..7).
- IDLE:
  - DQ_OUT=1.
  - On fall, go to SLOT.
  - In TX mode with the current TX bit = 0, drive DQ_OUT=0 in the same cycle SLOT is entered.
- SLOT (cnt counts the cycles dq_s is low):
  - TX: release DQ_OUT when cnt = TXHOLD_US·CLK_MHZ.
  - RX: capture dq_s at cnt = SAMPLE_US·CLK_MHZ. If rise comes first, the bit is 1.
  - On rise, classify the pulse by cnt:
    - cnt ≥ RSTMIN: pulse BUS_RESET. Clear bitn, clear TX_BUSY (no TX_DONE), discard the partial RX byte. Go to PD_WAIT.
    - cnt > SLOTMAX and < RSTMIN: pulse ERR. Clear bitn, discard the partial byte, keep TX_BUSY. Go to IDLE.
    - otherwise: the bit is complete and bitn increments.
      - bitn wraps 7→0 in RX: load RX_BYTE and pulse RX_VALID.
      - bitn wraps 7→0 in TX: clear TX_BUSY and pulse TX_DONE.
      - Go to IDLE.
- PD_WAIT:
  - DQ_OUT=1. After PDWAIT_US·CLK_MHZ cycles, go to PD_DRIVE.
  - A fall in this state aborts the presence pulse and goes to SLOT.
- PD_DRIVE: DQ_OUT=0 for PDLEN_US·CLK_MHZ cycles, then release and go to PD_REL.
- PD_REL: wait for dq_s=1 (master or pull-up), then go to IDLE.
- TX_LOAD:
  - Accepted only when TX_BUSY=0. It copies TX_BYTE into the shift register and sets TX_BUSY the next cycle.
  - TX_LOAD while busy is ignored.
  - A load in the same cycle as a bus reset loses the load.
- During a TX bit the block's own drive also holds dq_s low. Slot length is therefore always measured to the actual rise.
- nRST low, at any point including mid-presence or mid-slot: go to IDLE, DQ_OUT=1, clear all outputs and counters, and disarm TX.

## Timing
- DQ_IN to dq_s latency: 2 CLK.
- All edges and thresholds are measured on dq_s, so bus-level timing carries a constant 2-cycle offset.
- DQ_OUT is registered. At CLK_MHZ=50 the values are:
  - sample point: 1500 cycles;
  - TX hold: 1500 cycles;
  - slot max: 6000 cycles;
  - reset min: 20000 cycles;
  - presence wait: 1500 cycles;
  - presence length: 6000 cycles.
- RX_VALID and TX_DONE assert 1 cycle after the rise that ends the 8th slot.
- BUS_RESET asserts 1 cycle after the rise that ends the reset pulse.
- The presence pulse starts PDWAIT cycles later and lasts exactly PDLEN cycles.
- A fall occurring on the same cycle as the PD_WAIT timeout goes to SLOT; the fall wins.

## Test plan
- Master low 480 µs, then release → BUS_RESET pulse; DQ_OUT=0 from 30 µs to 150 µs after release; return to IDLE.
- Master writes 0xA5 (write-0 = 60 µs low, write-1 = 6 µs low, LSB first) → one RX_VALID, RX_BYTE=0xA5, no ERR.
- TX_LOAD with 0x3C, then 8 read slots (2 µs low each) → DQ_OUT low for 30 µs in slots 0,1,6,7 only; TX_DONE after slot 7; TX_BUSY=0.
- TX_LOAD 0xFF, 3 read slots, then a 500 µs reset → TX_BUSY drops without TX_DONE, presence pulse follows, and the next 8 write slots receive normally.
- 200 µs low pulse after 2 write bits → ERR pulse, partial byte discarded; the following 8 write slots of 0x01 give RX_BYTE=0x01.
- nRST asserted 50 µs into PD_DRIVE → DQ_OUT=1 immediately, all pulses 0; after release the block is IDLE and a new reset gets a full presence pulse.
